// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: state encoding, default frame geometry
// and the slot-index width helper used by both mux and demux sides.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int TDM_N_CH = 4;
    localparam int TDM_W    = 8;

    // Never returns 0, so a slot bus is always at least one bit wide
    function automatic int slotWidth(input int nCh);
        return (nCh <= 2) ? 1 : $clog2(nCh);
    endfunction

endpackage

// File: rtl/tdm_demux_rx_if.sv
// Bundle of the TDM receive link: serial sample input side and parallel frame output side.
interface tdm_demux_rx_if #(
    parameter int N_CH = tdm_pkg::TDM_N_CH,
    parameter int W    = tdm_pkg::TDM_W
);
    localparam int SW = tdm_pkg::slotWidth(N_CH);

    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] ch_out;
    logic              frame_valid;
    logic              locked;
    logic [SW-1:0]     slot;
    logic              sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_out, frame_valid, locked, slot, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_out, frame_valid, locked, slot, sync_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot position counter; clear wins over load-to-1, which wins over increment.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int SW   = slotWidth(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_load1,
    input  logic          i_inc,
    output logic [SW-1:0] o_slot,
    output logic          o_last
);

    logic [SW-1:0] r_slot;

    assign o_slot = r_slot;
    assign o_last = (r_slot == SW'(N_CH - 1));

    // Explicit wrap on the last slot keeps non-power-of-2 channel counts correct
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SW'(1);
        end else if (i_inc) begin
            r_slot <= o_last ? '0 : r_slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: tracks slot alignment from frame_sync, assembles N_CH samples per frame
// and publishes each complete frame on a registered bus with a one-cycle strobe.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int W    = TDM_W
) (
    input  logic          clk,
    input  logic          rst,
    tdm_demux_rx_if.slave bus
);

    localparam int SW = slotWidth(N_CH);

    tdm_state_t        r_state;
    logic              r_locked;
    logic [W-1:0]      r_shadow [N_CH];
    logic [N_CH*W-1:0] r_chOut;
    logic              r_frameValid;
    logic              r_syncErr;

    logic [SW-1:0]     w_slot;
    logic              w_last;
    logic              w_clear;
    logic              w_load1;
    logic              w_inc;
    logic              w_emit;
    logic              w_err;
    tdm_state_t        w_nextState;
    logic [N_CH*W-1:0] w_frame;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slotCounter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .o_slot  (w_slot),
        .o_last  (w_last)
    );

    // Any sync beat restarts a frame at slot 0; a missing sync at slot 0 drops lock
    always_comb begin
        w_clear     = 1'b0;
        w_load1     = 1'b0;
        w_inc       = 1'b0;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        w_nextState = r_state;
        if (bus.din_valid) begin
            if (r_state == HUNT) begin
                if (bus.frame_sync) begin
                    w_load1     = 1'b1;
                    w_nextState = LOCKED;
                end
            end else if (w_slot == '0) begin
                if (bus.frame_sync) begin
                    w_load1 = 1'b1;
                end else begin
                    w_clear     = 1'b1;
                    w_err       = 1'b1;
                    w_nextState = HUNT;
                end
            end else if (bus.frame_sync) begin
                w_load1 = 1'b1;
                w_err   = 1'b1;
            end else begin
                w_inc  = 1'b1;
                w_emit = w_last;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        for (int k = 0; k < N_CH - 1; k++) begin
            w_frame[k*W +: W] = r_shadow[k];
        end
        w_frame[(N_CH-1)*W +: W] = bus.din;
    end

    // The final sample bypasses the shadow so the frame emits on its own beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_load1) begin
            r_shadow[0] <= bus.din;
        end else if (w_inc) begin
            r_shadow[w_slot] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HUNT;
            r_locked     <= 1'b0;
            r_chOut      <= '0;
            r_frameValid <= 1'b0;
            r_syncErr    <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_locked     <= (w_nextState == LOCKED);
            r_frameValid <= w_emit;
            r_syncErr    <= w_err;
            if (w_emit) begin
                r_chOut <= w_frame;
            end
        end
    end

    assign bus.ch_out      = r_chOut;
    assign bus.frame_valid = r_frameValid;
    assign bus.locked      = r_locked;
    assign bus.slot        = w_slot;
    assign bus.sync_err    = r_syncErr;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed and randomized bench for tdm_demux_rx against a queue-based frame model.
module tb_tdm_demux_rx;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic clk;
    logic rst;

    tdm_demux_rx_if #(.N_CH(N_CH), .W(W)) bus ();

    tdm_demux_rx #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount  = 0;
    int totalCount = 0;

    // Reference model: a link is locked or not, and the partial frame is the list of
    // samples gathered since the last sync; its length is the next slot.
    logic [W-1:0]      partial [$];
    bit                mLocked;
    logic [N_CH*W-1:0] mChOut;
    bit                mFv;
    bit                mErr;

    task automatic modelReset();
        partial.delete();
        mLocked = 1'b0;
        mChOut  = '0;
        mFv     = 1'b0;
        mErr    = 1'b0;
    endtask

    task automatic modelBeat(input bit v, input bit s, input logic [W-1:0] d);
        mFv  = 1'b0;
        mErr = 1'b0;
        if (v) begin
            if (!mLocked) begin
                if (s) begin
                    partial = {d};
                    mLocked = 1'b1;
                end
            end else if (s) begin
                mErr    = (partial.size() != 0);
                partial = {d};
            end else if (partial.size() == 0) begin
                mErr    = 1'b1;
                mLocked = 1'b0;
            end else begin
                partial.push_back(d);
                if (partial.size() == N_CH) begin
                    for (int k = 0; k < N_CH; k++) begin
                        mChOut[k*W +: W] = partial[k];
                    end
                    mFv = 1'b1;
                    partial.delete();
                end
            end
        end
    endtask

    task automatic checkOne(input string name, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, " ch_out"},      64'(bus.ch_out),      64'(mChOut));
        checkOne({tag, " frame_valid"}, 64'(bus.frame_valid), 64'(mFv));
        checkOne({tag, " sync_err"},    64'(bus.sync_err),    64'(mErr));
        checkOne({tag, " locked"},      64'(bus.locked),      64'(mLocked));
        checkOne({tag, " slot"},        64'(bus.slot),        64'(partial.size()));
    endtask

    // Drives one cycle of input, lets the edge happen, then samples 1ns later
    task automatic applyStimulus(input string tag, input bit v, input bit s, input logic [W-1:0] d);
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = s;
        @(posedge clk);
        modelBeat(v, s, d);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        bit v;
        bit s;
        int fvCount;

        rst            = 1'b1;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;

        applyStimulus("lock0", 1, 1, 8'h11);
        applyStimulus("lock1", 1, 0, 8'h22);
        applyStimulus("lock2", 1, 0, 8'h33);
        applyStimulus("lock3", 1, 0, 8'h44);
        applyStimulus("lockIdle", 0, 0, 8'h00);

        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst2");
        #2;
        rst = 1'b0;
        applyStimulus("hunt0", 1, 0, 8'hAA);
        applyStimulus("hunt1", 1, 0, 8'hBB);
        applyStimulus("hunt2", 1, 1, 8'h01);
        applyStimulus("hunt3", 1, 0, 8'h02);
        applyStimulus("hunt4", 1, 0, 8'h03);
        applyStimulus("hunt5", 1, 0, 8'h04);

        applyStimulus("early0", 1, 1, 8'h10);
        applyStimulus("early1", 1, 0, 8'h20);
        applyStimulus("early2", 1, 1, 8'h30);
        applyStimulus("early3", 1, 0, 8'h40);
        applyStimulus("early4", 1, 0, 8'h50);
        applyStimulus("early5", 1, 0, 8'h60);

        applyStimulus("miss0", 1, 0, 8'h99);
        applyStimulus("miss1", 0, 0, 8'h00);

        applyStimulus("gap0", 1, 1, 8'hC1);
        applyStimulus("gap1", 0, 1, 8'hEE);
        applyStimulus("gap2", 1, 0, 8'hC2);
        applyStimulus("gap3", 0, 0, 8'hEE);
        applyStimulus("gap4", 1, 0, 8'hC3);
        applyStimulus("gap5", 0, 1, 8'hEE);
        applyStimulus("gap6", 1, 0, 8'hC4);

        fvCount = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N_CH; k++) begin
                applyStimulus("full", 1, (k == 0), 8'(16 * f + k + 1));
                if (bus.frame_valid) fvCount++;
            end
        end
        checkOne("fullRateFrames", 64'(fvCount), 64'd3);

        applyStimulus("mid0", 1, 1, 8'h5A);
        applyStimulus("mid1", 1, 0, 8'h5B);
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midReset");
        #2;
        rst = 1'b0;
        applyStimulus("fresh0", 1, 1, 8'h71);
        applyStimulus("fresh1", 1, 0, 8'h72);
        applyStimulus("fresh2", 1, 0, 8'h73);
        applyStimulus("fresh3", 1, 0, 8'h74);

        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            if (partial.size() == 0) s = ($urandom_range(0, 9) < 9);
            else                     s = ($urandom_range(0, 19) == 0);
            applyStimulus("rand", v, s, 8'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
